// File: rtl/json_drive_pkg.sv
// Shared constants, state encoding and sizing helpers for the JSON drive-command sender.
package json_drive_pkg;

  localparam logic [7:0] LBRACE   = 8'h7B;
  localparam logic [7:0] QUOTE    = 8'h22;
  localparam logic [7:0] COLON    = 8'h3A;
  localparam logic [7:0] COMMA    = 8'h2C;
  localparam logic [7:0] DOT      = 8'h2E;
  localparam logic [7:0] MINUS    = 8'h2D;
  localparam logic [7:0] RBRACE   = 8'h7D;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] DIGIT0   = 8'h30;
  localparam logic [7:0] LETTER_T = 8'h54;
  localparam logic [7:0] LETTER_L = 8'h4C;
  localparam logic [7:0] LETTER_R = 8'h52;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  // Longest frame: fixed punctuation plus two signed numbers.
  function automatic int max_frame_len(input int frac_digits);
    return 18 + 2 * (frac_digits + 2) + 2;
  endfunction

  // Widest rendered number: sign, integer digit, dot, fraction digits.
  function automatic int num_chars(input int frac_digits);
    return frac_digits + 3;
  endfunction

endpackage

// File: rtl/json_num_fmt.sv
// Combinational signed fixed-point to ASCII formatter; magnitude clamps to 1.0 (or 1.00).
// Character i of the result sits in chars[8*i +: 8]; count gives the number of valid characters.
module json_num_fmt
  import json_drive_pkg::*;
#(
  parameter int SPEED_W     = 8,
  parameter int FRAC_DIGITS = 1
) (
  input  logic [SPEED_W-1:0]             value,
  output logic [8*(FRAC_DIGITS+3)-1:0]   chars,
  output logic [2:0]                     count,
  output logic                           clamped
);

  localparam int unsigned SCALE = 10 ** FRAC_DIGITS;
  localparam logic [SPEED_W:0] SCALE_W = (SPEED_W + 1)'(SCALE);

  logic                            neg;
  logic [SPEED_W:0]                mag;
  logic [SPEED_W:0]                mag_clamped;
  int unsigned                     mag_int;
  logic [8*(FRAC_DIGITS+2)-1:0]    body;

  // One extra bit keeps the most-negative input representable after negation.
  assign neg         = value[SPEED_W-1];
  assign mag         = neg ? ((~{1'b1, value}) + (SPEED_W + 1)'(1)) : {1'b0, value};
  assign clamped     = mag > SCALE_W;
  assign mag_clamped = clamped ? SCALE_W : mag;
  assign mag_int     = 32'(mag_clamped);

  assign body[7:0]  = DIGIT0 + 8'(mag_int / SCALE);
  assign body[15:8] = DOT;

  generate
    for (genvar gi = 0; gi < FRAC_DIGITS; gi++) begin : g_frac
      localparam int unsigned DIV = 10 ** (FRAC_DIGITS - 1 - gi);
      assign body[8*(gi+2) +: 8] = DIGIT0 + 8'((mag_int / DIV) % 10);
    end
  endgenerate

  assign chars = neg ? {body, MINUS} : {8'h00, body};
  assign count = neg ? 3'(FRAC_DIGITS + 3) : 3'(FRAC_DIGITS + 2);

endmodule

// File: rtl/json_drive_tx.sv
// Streams {"T":t,"L":l,"R":r}\n frames to a UART byte sink, with a one-entry pending command slot.
// Optional JSON_DRIVE_TX_STATS_EN adds frames_sent and clamp_count counters.
module json_drive_tx
  import json_drive_pkg::*;
#(
  parameter int SPEED_W     = 8,
  parameter int FRAC_DIGITS = 1,
  parameter int CMD_TYPE    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [SPEED_W-1:0] cmd_left,
  input  logic [SPEED_W-1:0] cmd_right,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy
`ifdef JSON_DRIVE_TX_STATS_EN
  ,
  output logic [15:0]        frames_sent,
  output logic [15:0]        clamp_count
`endif
);

  localparam int MAX_LEN = max_frame_len(FRAC_DIGITS);
  localparam int NCH     = num_chars(FRAC_DIGITS);
  localparam int IDX_W   = $clog2(MAX_LEN + 1);

  state_t state_reg, state_next;

  logic [SPEED_W-1:0] act_left_reg, act_right_reg;
  logic [SPEED_W-1:0] slot_left_reg, slot_right_reg;
  logic               slot_full_reg;
  logic [IDX_W-1:0]   idx_reg, len_reg;
  logic [7:0]         buf_reg [MAX_LEN];
  logic [7:0]         frame_comb [MAX_LEN];

  logic [8*NCH-1:0]   left_chars, right_chars;
  logic [2:0]         left_cnt, right_cnt;
  logic               left_clamped, right_clamped;
  logic [IDX_W-1:0]   right_base, tail_base;

  logic accept, tx_fire, last_byte;

  assign accept    = cmd_valid && cmd_ready;
  assign tx_fire   = tx_valid && tx_ready;
  assign last_byte = (idx_reg == len_reg - IDX_W'(1));

  json_num_fmt #(.SPEED_W(SPEED_W), .FRAC_DIGITS(FRAC_DIGITS)) u_fmt_left (
    .value   (act_left_reg),
    .chars   (left_chars),
    .count   (left_cnt),
    .clamped (left_clamped)
  );

  json_num_fmt #(.SPEED_W(SPEED_W), .FRAC_DIGITS(FRAC_DIGITS)) u_fmt_right (
    .value   (act_right_reg),
    .chars   (right_chars),
    .count   (right_cnt),
    .clamped (right_clamped)
  );

  // Left number always starts at byte 11; everything after it shifts with its length.
  assign right_base = IDX_W'(11) + IDX_W'(left_cnt);
  assign tail_base  = right_base + IDX_W'(5) + IDX_W'(right_cnt);

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) frame_comb[i] = 8'h00;
    frame_comb[0]  = LBRACE;
    frame_comb[1]  = QUOTE;
    frame_comb[2]  = LETTER_T;
    frame_comb[3]  = QUOTE;
    frame_comb[4]  = COLON;
    frame_comb[5]  = DIGIT0 + 8'(CMD_TYPE);
    frame_comb[6]  = COMMA;
    frame_comb[7]  = QUOTE;
    frame_comb[8]  = LETTER_L;
    frame_comb[9]  = QUOTE;
    frame_comb[10] = COLON;
    for (int i = 0; i < NCH; i++) begin
      if (i < int'(left_cnt)) frame_comb[11 + i] = left_chars[8*i +: 8];
    end
    frame_comb[right_base]             = COMMA;
    frame_comb[right_base + IDX_W'(1)] = QUOTE;
    frame_comb[right_base + IDX_W'(2)] = LETTER_R;
    frame_comb[right_base + IDX_W'(3)] = QUOTE;
    frame_comb[right_base + IDX_W'(4)] = COLON;
    for (int i = 0; i < NCH; i++) begin
      if (i < int'(right_cnt)) frame_comb[right_base + IDX_W'(5 + i)] = right_chars[8*i +: 8];
    end
    frame_comb[tail_base]             = RBRACE;
    frame_comb[tail_base + IDX_W'(1)] = LF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (accept) state_next = LOAD;
      LOAD: state_next = SEND;
      SEND: if (tx_fire && last_byte) state_next = (slot_full_reg || accept) ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_valid  = (state_reg == SEND);
    tx_data   = tx_valid ? buf_reg[idx_reg] : 8'h00;
    cmd_ready = !slot_full_reg;
    busy      = (state_reg != IDLE) || slot_full_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_left_reg   <= '0;
      act_right_reg  <= '0;
      slot_left_reg  <= '0;
      slot_right_reg <= '0;
      slot_full_reg  <= 1'b0;
      idx_reg        <= '0;
      len_reg        <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            act_left_reg  <= cmd_left;
            act_right_reg <= cmd_right;
          end
        end
        LOAD: begin
          idx_reg <= '0;
          len_reg <= IDX_W'(18) + IDX_W'(left_cnt) + IDX_W'(right_cnt);
          if (accept) begin
            slot_left_reg  <= cmd_left;
            slot_right_reg <= cmd_right;
            slot_full_reg  <= 1'b1;
          end
        end
        SEND: begin
          if (tx_fire && last_byte) begin
            // A command arriving on the final byte skips the slot and goes straight to active.
            if (slot_full_reg) begin
              act_left_reg  <= slot_left_reg;
              act_right_reg <= slot_right_reg;
              slot_full_reg <= 1'b0;
            end else if (accept) begin
              act_left_reg  <= cmd_left;
              act_right_reg <= cmd_right;
            end
          end else begin
            if (tx_fire) idx_reg <= idx_reg + IDX_W'(1);
            if (accept) begin
              slot_left_reg  <= cmd_left;
              slot_right_reg <= cmd_right;
              slot_full_reg  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_reg == LOAD) begin
      for (int i = 0; i < MAX_LEN; i++) buf_reg[i] <= frame_comb[i];
    end
  end

`ifdef JSON_DRIVE_TX_STATS_EN
  logic [15:0] frames_sent_reg, clamp_count_reg;

  function automatic logic over_range(input logic [SPEED_W-1:0] v);
    logic [SPEED_W:0] m;
    m = v[SPEED_W-1] ? ((~{1'b1, v}) + (SPEED_W + 1)'(1)) : {1'b0, v};
    return m > (SPEED_W + 1)'(10 ** FRAC_DIGITS);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_sent_reg <= '0;
      clamp_count_reg <= '0;
    end else begin
      if (tx_fire && last_byte) frames_sent_reg <= frames_sent_reg + 16'd1;
      if (accept && (over_range(cmd_left) || over_range(cmd_right)) && clamp_count_reg != 16'hFFFF)
        clamp_count_reg <= clamp_count_reg + 16'd1;
    end
  end

  assign frames_sent = frames_sent_reg;
  assign clamp_count = clamp_count_reg;
`endif

endmodule

// File: tb/tb_json_drive_tx.sv
// Directed bench for json_drive_tx: table of frames on two instances (1 and 2 fraction digits)
// plus back-to-back queueing and mid-frame reset sequences.
module tb_json_drive_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [7:0] cmd_left  [2];
  logic [7:0] cmd_right [2];
  logic [7:0] tx_data   [2];
  logic       tx_valid  [2];
  logic       tx_ready  [2];
  logic       busy      [2];
`ifdef JSON_DRIVE_TX_STATS_EN
  logic [15:0] frames_sent [2];
  logic [15:0] clamp_count [2];
`endif

  json_drive_tx #(.SPEED_W(8), .FRAC_DIGITS(1), .CMD_TYPE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_left(cmd_left[0]), .cmd_right(cmd_right[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .busy(busy[0])
`ifdef JSON_DRIVE_TX_STATS_EN
    , .frames_sent(frames_sent[0]), .clamp_count(clamp_count[0])
`endif
  );

  json_drive_tx #(.SPEED_W(8), .FRAC_DIGITS(2), .CMD_TYPE(1)) u_dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_left(cmd_left[1]), .cmd_right(cmd_right[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .busy(busy[1])
`ifdef JSON_DRIVE_TX_STATS_EN
    , .frames_sent(frames_sent[1]), .clamp_count(clamp_count[1])
`endif
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         d;
    logic [7:0] l;
    logic [7:0] r;
    int         pct;
    string      exp;
  } vec_t;

  vec_t vt [8];

  function automatic string printable(input string s);
    string res = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0A) res = {res, "\\n"};
      else               res = {res, s.substr(i, i)};
    end
    return res;
  endfunction

  task automatic chk_int(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got '%s' expected '%s'", name, printable(act), printable(exp));
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting clock edge.
  task automatic send_cmd(input int d, input logic [7:0] l, input logic [7:0] r);
    bit ok = 0;
    cmd_left[d]  = l;
    cmd_right[d] = r;
    cmd_valid[d] = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (cmd_ready[d]) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    cmd_valid[d] = 1'b0;
    chk_int("cmd_accept", 32'(ok), 32'd1);
  endtask

  // Collects one frame, driving tx_ready with the given percentage; gap counts idle cycles before byte 0.
  task automatic collect(input int d, input int pct, output string s, output int gap);
    logic       stall = 1'b0;
    logic [7:0] last  = 8'h00;
    int         bad   = 0;
    bit         done  = 0;
    s   = "";
    gap = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      if (stall && tx_data[d] !== last) bad++;
      tx_ready[d] = ($urandom_range(99) < pct);
      if (!tx_valid[d]) begin
        if (s.len() == 0) gap++;
        else              bad++;
        stall = 1'b0;
      end else if (tx_ready[d]) begin
        s = {s, " "};
        s.putc(s.len() - 1, tx_data[d]);
        if (tx_data[d] == 8'h0A) done = 1;
        stall = 1'b0;
      end else begin
        stall = 1'b1;
        last  = tx_data[d];
      end
    end
    chk_int("frame_done", 32'(done), 32'd1);
    chk_int("handshake_rules", 32'(bad), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string s, sa, sb, sc;
    int    gap, gb, gc;
    int    cnt;

    vt[0] = '{0, 8'd5,   8'd0,   100, "{\"T\":1,\"L\":0.5,\"R\":0.0}\n"};
    vt[1] = '{0, 8'hFD,  8'h80,  100, "{\"T\":1,\"L\":-0.3,\"R\":-1.0}\n"};
    vt[2] = '{0, 8'd10,  8'hF6,  30,  "{\"T\":1,\"L\":1.0,\"R\":-1.0}\n"};
    vt[3] = '{0, 8'd11,  8'd127, 30,  "{\"T\":1,\"L\":1.0,\"R\":1.0}\n"};
    vt[4] = '{0, 8'd9,   8'hFF,  50,  "{\"T\":1,\"L\":0.9,\"R\":-0.1}\n"};
    vt[5] = '{1, 8'd100, 8'hF9,  100, "{\"T\":1,\"L\":1.00,\"R\":-0.07}\n"};
    vt[6] = '{1, 8'd45,  8'h9B,  30,  "{\"T\":1,\"L\":0.45,\"R\":-1.00}\n"};
    vt[7] = '{1, 8'd0,   8'd99,  100, "{\"T\":1,\"L\":0.00,\"R\":0.99}\n"};

    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0;
      cmd_left[d]  = 8'h00;
      cmd_right[d] = 8'h00;
      tx_ready[d]  = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk_int("reset_tx_valid", 32'(tx_valid[0]), 32'd0);
    chk_int("reset_tx_data", 32'(tx_data[0]), 32'h00);
    chk_int("reset_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk_int("reset_busy", 32'(busy[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send_cmd(vt[i].d, vt[i].l, vt[i].r);
      chk_int("latency_load_gap", 32'(tx_valid[vt[i].d]), 32'd0);
      collect(vt[i].d, vt[i].pct, s, gap);
      chk_int("latency_first_byte", 32'(gap), 32'd0);
      chk_str("frame_bytes", s, vt[i].exp);
      $display("vec %0d dut%0d L=%0d R=%0d -> %s", i, vt[i].d + 1,
               $signed(vt[i].l), $signed(vt[i].r), printable(s));
`ifdef JSON_DRIVE_TX_STATS_EN
      if (i == 1) begin
        chk_int("clamp_count_after_v1", 32'(clamp_count[0]), 32'd1);
        chk_int("frames_sent_after_v1", 32'(frames_sent[0]), 32'd2);
      end
      if (i == 7) begin
        chk_int("clamp_count_dut2", 32'(clamp_count[1]), 32'd1);
        chk_int("frames_sent_dut2", 32'(frames_sent[1]), 32'd3);
      end
`endif
      @(negedge clk);
      chk_int("idle_busy", 32'(busy[vt[i].d]), 32'd0);
    end

    // Back-to-back: A in flight, B queued, C held off until the slot frees.
    fork
      begin
        send_cmd(0, 8'd1, 8'd2);
        send_cmd(0, 8'hFB, 8'd7);
        chk_int("c_held_off_ready", 32'(cmd_ready[0]), 32'd0);
        chk_int("c_held_off_busy", 32'(busy[0]), 32'd1);
        send_cmd(0, 8'hEC, 8'd3);
      end
      begin
        collect(0, 100, sa, gap);
        collect(0, 100, sb, gb);
        collect(0, 100, sc, gc);
      end
    join
    chk_str("b2b_frame_a", sa, "{\"T\":1,\"L\":0.1,\"R\":0.2}\n");
    chk_str("b2b_frame_b", sb, "{\"T\":1,\"L\":-0.5,\"R\":0.7}\n");
    chk_str("b2b_frame_c", sc, "{\"T\":1,\"L\":-1.0,\"R\":0.3}\n");
    chk_int("b2b_gap_b", 32'(gb), 32'd1);
    chk_int("b2b_gap_c", 32'(gc), 32'd1);
    $display("b2b A=%s B=%s C=%s gaps=%0d,%0d", printable(sa), printable(sb), printable(sc), gb, gc);
`ifdef JSON_DRIVE_TX_STATS_EN
    chk_int("clamp_count_b2b", 32'(clamp_count[0]), 32'd3);
    chk_int("frames_sent_b2b", 32'(frames_sent[0]), 32'd8);
`endif
    @(negedge clk);

    // Reset while the 10th byte is on the bus.
    send_cmd(0, 8'd3, 8'd4);
    tx_ready[0] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx_valid[0]) cnt++;
      if (cnt == 10) break;
    end
    chk_int("reset_reached_byte10", 32'(cnt), 32'd10);
    rst = 1'b1;
    #1;
    chk_int("midframe_tx_valid", 32'(tx_valid[0]), 32'd0);
    chk_int("midframe_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk_int("midframe_busy", 32'(busy[0]), 32'd0);
`ifdef JSON_DRIVE_TX_STATS_EN
    chk_int("midframe_frames_sent", 32'(frames_sent[0]), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_cmd(0, 8'd5, 8'd0);
    collect(0, 100, s, gap);
    chk_int("post_reset_first_byte", 32'(gap), 32'd0);
    chk_str("post_reset_frame", s, "{\"T\":1,\"L\":0.5,\"R\":0.0}\n");
    $display("post-reset frame -> %s", printable(s));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/json_drive_tx.md
Name: json_drive_tx

Overview:
- Parametrised successor to the fixed-string forward-command sender.
- Formats a drive command `{"T":<type>,"L":<left>,"R":<right>}\n` as ASCII JSON from signed numeric wheel speeds and streams it byte-by-byte to `uart_tx` over a valid/ready handshake.
- Sits between the NAVIGATE_FSM command logic and the `uart_tx` instance driving the rover serial link.
- Includes a one-entry pending-command buffer, so a new command can be queued while a frame is in flight.

Parameters:
- SPEED_W, 8, width of signed speed inputs (two's complement).
- FRAC_DIGITS, 1, decimal fraction digits emitted (legal 1..2); speeds are in units of 10^-FRAC_DIGITS.
- CMD_TYPE, 1, value of the "T" field (legal 0..9, single ASCII digit).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  pending slot free; command accepted when cmd_valid && cmd_ready
- cmd_left  in  SPEED_W  signed left speed
- cmd_right  in  SPEED_W  signed right speed
- tx_data  out  8  byte to uart_tx
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  uart_tx ready; byte consumed when tx_valid && tx_ready
- busy  out  1  frame in flight or pending

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - Reset `rst` is asynchronous and active-high.
  - All state clears immediately on `rst`; any partial frame is aborted without a trailing byte.
- Reset values: tx_valid=0, tx_data=8'h00, cmd_ready=1, busy=0, state=IDLE, pending slot empty.
- Number format:
  - Optional '-' when the value is negative.
  - One integer digit, then '.', then FRAC_DIGITS digits.
  - Magnitude is clamped to 10^FRAC_DIGITS, so the maximum rendered value is 1.0 or 1.00.
  - The most-negative input clamps to -1.0 with no overflow.
  - Zero renders without a sign.
- Frame length = 18 + 2*(FRAC_DIGITS+2) + number of negative fields (24 for FRAC_DIGITS=1, both fields non-negative).
- States:
  - IDLE:
    - On accept, latch the speeds into the active registers; go to LOAD.
  - LOAD:
    - One cycle; formatter results are registered into a character buffer and length; char index set to 0; go to SEND.
  - SEND:
    - tx_valid=1 with tx_data=buf[idx].
    - On handshake, idx increments and the next byte is presented in the following cycle; tx_valid stays high between bytes.
    - On the handshake of the final byte (8'h0A), go to LOAD if the slot is pending (slot moves to active, slot cleared), else to IDLE with tx_valid=0.
- Latency: accept at cycle N → LOAD at N+1 → first byte '{' with tx_valid=1 at N+2.
- Handshake rules:
  - tx_data is stable while tx_valid && !tx_ready.
  - tx_valid never drops mid-frame except on reset.
- Pending slot:
  - While in LOAD/SEND, an accept stores the command in the slot.
  - cmd_ready=0 while the slot is full.
  - If a slot-freeing transition and an accept coincide, the new command enters the slot in the same cycle; cmd_ready is registered, so there is no loss.
- busy = (state!=IDLE) || slot full.

Optional Feature:
- JSON_DRIVE_TX_STATS_EN defined:
  - Adds outputs frames_sent[15:0] (increments on each final-byte handshake, wraps at 16'hFFFF→0) and clamp_count[15:0] (increments once per accepted command where either speed was clamped, saturates at 16'hFFFF).
  - Both reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package json_drive_pkg:
  - ASCII constants (LBRACE 8'h7B, QUOTE 8'h22, COLON 8'h3A, COMMA 8'h2C, DOT 8'h2E, MINUS 8'h2D, RBRACE 8'h7D, LF 8'h0A, DIGIT0 8'h30).
  - State enum typedef (IDLE, LOAD, SEND).
  - Function computing maximum frame length from FRAC_DIGITS.
- Sub-module json_num_fmt:
  - Combinational signed-to-ASCII formatter with clamp.
  - Outputs a char array, character count and clamped flag; instantiated twice (left, right).

Test Plan:
- FRAC_DIGITS=1, left=5, right=0, tx_ready=1:
  - Exactly 7B 22 54 22 3A 31 2C 22 4C 22 3A 30 2E 35 2C 22 52 22 3A 30 2E 30 7D 0A.
  - First byte at accept+2.
- left=-3, right=-128 (SPEED_W=8) → `{"T":1,"L":-0.3,"R":-1.0}\n`, 26 bytes, clamp_count=1 with STATS_EN.
- FRAC_DIGITS=2, left=100, right=-7 → `{"T":1,"L":1.00,"R":-0.07}\n`.
- Random tx_ready backpressure (~30% high) → byte sequence unchanged; tx_data stable whenever tx_valid && !tx_ready.
- Three back-to-back commands (A, B, C) during frame A:
  - B is queued.
  - C is held off with cmd_ready=0.
  - Frames A, B, then C are sent contiguously, with LOAD gaps only.
- Assert rst at byte 10 of a frame:
  - tx_valid=0 in the same cycle, cmd_ready=1, busy=0.
  - The next command produces a complete fresh frame starting with 7B.
